// File: rtl/i2c_target_regfile.sv
// I2C target with an internal byte register file.
// SCL/SDA are oversampled on CLK_IN. The block supports a register pointer,
// auto-incrementing writes and reads, and repeated START. It also has a
// host-side read port with a one-cycle registered latency.
module i2c_target_regfile #(
  parameter logic [6:0]  SLAVE_ADDR  = 7'h50,
  parameter int unsigned DEPTH       = 256,
  parameter int unsigned PTR_W       = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             CLK_IN,
  input  logic             RESET_IN,
  input  logic             SCL_IN,
  input  logic             SDA_IN,
  output logic             SDA_OE,
  output logic             BUSY,
  output logic             WR_STROBE,
  output logic [PTR_W-1:0] WR_PTR,
  output logic [7:0]       WR_DATA,
  input  logic [PTR_W-1:0] RD_ADDR_IN,
  output logic [7:0]       RD_DATA_OUT
);

  localparam logic [8:0]       DepthB  = 9'(DEPTH);
  localparam logic [PTR_W:0]   RdDepth = (PTR_W + 1)'(DEPTH);
  localparam logic [PTR_W-1:0] LastIdx = PTR_W'(DEPTH - 1);

  typedef enum logic [3:0] {
    StIdle, StAddr, StAddrAck, StPtr, StPtrAck,
    StWdata, StWdataAck, StRdata, StRack, StWait
  } state_e;

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] scl_sync_q, sda_sync_q;
  logic                   scl_prev_q, sda_prev_q;
  logic [3:0]             cnt_q, cnt_d;
  logic [7:0]             shift_q, shift_d;
  logic [PTR_W-1:0]       ptr_q, ptr_d;
  logic                   oe_q, oe_d;
  logic                   busy_q, busy_d;
  logic                   rack_q, rack_d;
  logic                   wr_stb_q, wr_stb_d;
  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
  logic [7:0]             wr_data_q, wr_data_d;
  logic [7:0]             rd_data_q;
  logic                   mem_we;
  logic [7:0]             mem_q [DEPTH];

  logic             scl_s, sda_s;
  logic             scl_rise, scl_fall, start_ev, stop_ev;
  logic [7:0]       rd_byte;
  logic [PTR_W-1:0] next_ptr;

  assign scl_s    = scl_sync_q[SYNC_STAGES-1];
  assign sda_s    = sda_sync_q[SYNC_STAGES-1];
  assign scl_rise = scl_s & ~scl_prev_q;
  assign scl_fall = ~scl_s & scl_prev_q;
  // SCL must be stable high across both samples so a data edge is not mistaken for START/STOP.
  assign start_ev = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
  assign stop_ev  = scl_s & scl_prev_q & ~sda_prev_q & sda_s;
  assign rd_byte  = mem_q[ptr_q];
  assign next_ptr = (ptr_q == LastIdx) ? '0 : ptr_q + PTR_W'(1);

  assign SDA_OE      = oe_q;
  assign BUSY        = busy_q;
  assign WR_STROBE   = wr_stb_q;
  assign WR_PTR      = wr_ptr_q;
  assign WR_DATA     = wr_data_q;
  assign RD_DATA_OUT = rd_data_q;

  // Protocol state machine: next state, shift register, pointer and SDA drive.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shift_d   = shift_q;
    ptr_d     = ptr_q;
    oe_d      = oe_q;
    busy_d    = busy_q;
    rack_d    = rack_q;
    wr_stb_d  = 1'b0;
    wr_ptr_d  = wr_ptr_q;
    wr_data_d = wr_data_q;
    mem_we    = 1'b0;

    if (start_ev) begin
      state_d = StAddr;
      cnt_d   = '0;
      oe_d    = 1'b0;
    end else if (stop_ev) begin
      // A partially shifted byte is simply dropped here.
      state_d = StIdle;
      cnt_d   = '0;
      oe_d    = 1'b0;
      busy_d  = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: oe_d = 1'b0;

        StAddr, StPtr, StWdata: begin
          if (scl_rise && cnt_q != 4'd8) begin
            shift_d = {shift_q[6:0], sda_s};
            cnt_d   = cnt_q + 4'd1;
          end else if (scl_fall && cnt_q == 4'd8) begin
            cnt_d = '0;
            if (state_q == StAddr) begin
              if (shift_q[7:1] == SLAVE_ADDR) begin
                state_d = StAddrAck;
                oe_d    = 1'b1;
                busy_d  = 1'b1;
              end else begin
                state_d = StWait;
                busy_d  = 1'b0;
              end
            end else if (state_q == StPtr) begin
              if ({1'b0, shift_q} < DepthB) begin
                ptr_d   = PTR_W'(shift_q);
                state_d = StPtrAck;
                oe_d    = 1'b1;
              end else begin
                state_d = StWait;
                busy_d  = 1'b0;
              end
            end else begin
              mem_we    = 1'b1;
              wr_stb_d  = 1'b1;
              wr_ptr_d  = ptr_q;
              wr_data_d = shift_q;
              ptr_d     = next_ptr;
              state_d   = StWdataAck;
              oe_d      = 1'b1;
            end
          end
        end

        // shift_q still holds the address byte; bit 0 is R/W.
        StAddrAck: begin
          if (scl_fall) begin
            cnt_d = '0;
            if (shift_q[0]) begin
              state_d = StRdata;
              shift_d = rd_byte;
              oe_d    = ~rd_byte[7];
            end else begin
              state_d = StPtr;
              oe_d    = 1'b0;
            end
          end
        end

        StPtrAck, StWdataAck: begin
          if (scl_fall) begin
            state_d = StWdata;
            cnt_d   = '0;
            oe_d    = 1'b0;
          end
        end

        StRdata: begin
          if (scl_fall) begin
            if (cnt_q == 4'd7) begin
              oe_d    = 1'b0;
              ptr_d   = next_ptr;
              state_d = StRack;
            end else begin
              cnt_d   = cnt_q + 4'd1;
              shift_d = {shift_q[6:0], 1'b0};
              oe_d    = ~shift_q[6];
            end
          end
        end

        StRack: begin
          if (scl_rise) begin
            rack_d = sda_s;
          end else if (scl_fall) begin
            if (!rack_q) begin
              state_d = StRdata;
              cnt_d   = '0;
              shift_d = rd_byte;
              oe_d    = ~rd_byte[7];
            end else begin
              state_d = StWait;
              oe_d    = 1'b0;
              busy_d  = 1'b0;
            end
          end
        end

        StWait: begin
          oe_d   = 1'b0;
          busy_d = 1'b0;
        end

        default: state_d = StIdle;
      endcase
    end
  end

  // Synchronisers, edge history, FSM registers and the host read port.
  always_ff @(posedge CLK_IN) begin
    if (RESET_IN) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
      state_q    <= StIdle;
      cnt_q      <= '0;
      shift_q    <= '0;
      ptr_q      <= '0;
      oe_q       <= 1'b0;
      busy_q     <= 1'b0;
      rack_q     <= 1'b0;
      wr_stb_q   <= 1'b0;
      wr_ptr_q   <= '0;
      wr_data_q  <= '0;
      rd_data_q  <= '0;
    end else begin
      scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], SCL_IN};
      sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], SDA_IN};
      scl_prev_q <= scl_s;
      sda_prev_q <= sda_s;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      ptr_q      <= ptr_d;
      oe_q       <= oe_d;
      busy_q     <= busy_d;
      rack_q     <= rack_d;
      wr_stb_q   <= wr_stb_d;
      wr_ptr_q   <= wr_ptr_d;
      wr_data_q  <= wr_data_d;
      // Same-cycle write to this index is not forwarded: old data is returned.
      if ({1'b0, RD_ADDR_IN} < RdDepth) begin
        rd_data_q <= mem_q[RD_ADDR_IN];
      end else begin
        rd_data_q <= 8'h00;
      end
    end
  end

  // Register file storage; contents survive reset.
  always_ff @(posedge CLK_IN) begin
    if (mem_we && !RESET_IN) begin
      mem_q[ptr_q] <= shift_q;
    end
  end

endmodule
